// File: rtl/bfm_apbslave_pkg.sv
// bfm_apbslave_pkg: shared state encoding and address/counter constants for the APB completer BFM.
package bfm_apbslave_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam int IDX_LSB  = 2;
  localparam int SLOT_MSB = 27;
  localparam int SLOT_LSB = 24;
  localparam int ERR_MSB  = 23;
  localparam int CNT_W    = 4;
  localparam int XFER_W   = 16;
endpackage

// File: rtl/bfm_apbslave_ram.sv
// bfm_apbslave_ram: single-port 32-bit RAM, synchronous write, registered read, no reset.
module bfm_apbslave_ram #(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AWIDTH-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem_q [2**AWIDTH];
  logic [31:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/bfm_apbslave_resp.sv
// bfm_apbslave_resp: APB completer BFM with RAM, programmable wait states, PSLVERR and bench statistics.
module bfm_apbslave_resp
  import bfm_apbslave_pkg::*;
#(
  parameter int AWIDTH      = 8,
  parameter int WAIT_STATES = 0,
  parameter int ERR_EN      = 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [15:0] XFER_CNT,
  output logic        PROT_ERR
);
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [AWIDTH-1:0]   idx_q, idx_d;
  logic                wr_q, wr_d, err_q, err_d, vld_q, vld_d, prot_q, prot_d;
  logic [XFER_W-1:0]   xfer_q, xfer_d;
  logic                setup, acc, addr_err, ram_we, ram_re;
  logic [AWIDTH-1:0]   paddr_idx;
  logic [31:0]         ram_rdata;
  logic                unused_paddr;
  assign setup     = PSEL & ~PENABLE;
  assign acc       = PSEL & PENABLE;
  assign paddr_idx = PADDR[AWIDTH+IDX_LSB-1:IDX_LSB];
  // Shifting out the word-index bits leaves exactly the error window; empty when AWIDTH=22.
  assign addr_err  = (ERR_EN != 0) && ((PADDR[ERR_MSB:0] >> (AWIDTH + IDX_LSB)) != '0);
  assign unused_paddr = ^{PADDR[31:SLOT_MSB+1], PADDR[SLOT_MSB:SLOT_LSB], PADDR[IDX_LSB-1:0]};
  assign PREADY    = (state_q == ACCESS) && (cnt_q == '0);
  assign PSLVERR   = PREADY & err_q;
  assign PRDATA    = vld_q ? ram_rdata : '0;
  assign XFER_CNT  = xfer_q;
  assign PROT_ERR  = prot_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    err_d   = err_q;
    vld_d   = vld_q;
    xfer_d  = xfer_q;
    prot_d  = prot_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    if (state_q == IDLE) begin
      if (setup) begin
        state_d = ACCESS;
        cnt_d   = CNT_W'(WAIT_STATES);
        idx_d   = paddr_idx;
        wr_d    = PWRITE;
        err_d   = addr_err;
        vld_d   = ~PWRITE & ~addr_err;
        ram_re  = ~PWRITE & ~addr_err;
      end else if (acc) begin
        prot_d = 1'b1;
      end
    end else if (!acc) begin
      prot_d  = 1'b1;
      state_d = IDLE;
    end else if (!PREADY) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      ram_we  = wr_q & ~err_q & ~PRESET;
      xfer_d  = xfer_q + 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      xfer_q  <= '0;
      prot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      xfer_q  <= xfer_d;
      prot_q  <= prot_d;
    end
  end
  bfm_apbslave_ram #(.AWIDTH(AWIDTH)) u_ram (
    .clk  (PCLK),
    .we   (ram_we),
    .re   (ram_re),
    .addr (state_q == ACCESS ? idx_q : paddr_idx),
    .wdata(PWDATA),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_bfm_apbslave_resp.sv
// tb_bfm_apbslave_resp: directed checks on four BFM instances (WS=0, WS=3, WS=2, ERR_EN=0).
module tb_bfm_apbslave_resp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  psel = '0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata [4];
  logic [15:0] xcnt [4];
  logic [3:0]  pready, pslverr, prot;
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    bfm_apbslave_resp #(
      .AWIDTH(8),
      .WAIT_STATES(g == 1 ? 3 : (g == 2 ? 2 : 0)),
      .ERR_EN(g == 3 ? 0 : 1)
    ) u_dut (
      .PCLK(clk), .PRESET(rst), .PSEL(psel[g]), .PADDR(paddr), .PWRITE(pwrite),
      .PENABLE(penable), .PWDATA(pwdata), .PRDATA(prdata[g]), .PREADY(pready[g]),
      .PSLVERR(pslverr[g]), .XFER_CNT(xcnt[g]), .PROT_ERR(prot[g])
    );
  end

  // Called at a negedge; returns at the negedge after the completion edge with the bus idle.
  task automatic apb(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output int cyc, output int lows);
    bit done = 0;
    rd = '0; err = 1'b0; cyc = 1; lows = 0;
    psel[i] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      cyc++;
      if (pready[i]) begin rd = prdata[i]; err = pslverr[i]; done = 1; end
      else lows++;
      @(negedge clk);
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout dut%0d: PREADY got 0 want 1", i);
    end
    psel[i] = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (pready[i] !== 1'b0) begin n_fail++; $display("FAIL rst_pready dut%0d got %b want 0", i, pready[i]); end
      n_cmp++; if (pslverr[i] !== 1'b0) begin n_fail++; $display("FAIL rst_pslverr dut%0d got %b want 0", i, pslverr[i]); end
      n_cmp++; if (prdata[i] !== 32'h0) begin n_fail++; $display("FAIL rst_prdata dut%0d got %h want 0", i, prdata[i]); end
      n_cmp++; if (xcnt[i] !== 16'h0) begin n_fail++; $display("FAIL rst_xfer dut%0d got %0d want 0", i, xcnt[i]); end
      n_cmp++; if (prot[i] !== 1'b0) begin n_fail++; $display("FAIL rst_prot dut%0d got %b want 0", i, prot[i]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic err; int cyc, lows;
    apb(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, err, cyc, lows);
    n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL basic_wr_len got %0d want 2", cyc); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_wr_err got %b want 0", err); end
    apb(0, 1'b0, 32'h10, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd got %h want deadbeef", rd); end
    n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL basic_rd_len got %0d want 2", cyc); end
    n_cmp++; if (xcnt[0] !== 16'd2) begin n_fail++; $display("FAIL basic_xfer got %0d want 2", xcnt[0]); end
    n_cmp++; if (prdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_hold got %h want deadbeef", prdata[0]); end
  endtask

  task automatic test_wait();
    logic [31:0] rd; logic err; int cyc, lows;
    apb(1, 1'b1, 32'h10, 32'hDEADBEEF, rd, err, cyc, lows);
    n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL wait_wr_len got %0d want 5", cyc); end
    apb(1, 1'b0, 32'h10, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (lows !== 3) begin n_fail++; $display("FAIL wait_lows got %0d want 3", lows); end
    n_cmp++; if (cyc !== 5) begin n_fail++; $display("FAIL wait_rd_len got %0d want 5", cyc); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wait_rd got %h want deadbeef", rd); end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic err; int cyc, lows;
    apb(0, 1'b1, 32'h00100010, 32'h12345678, rd, err, cyc, lows);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_wr_slverr got %b want 1", err); end
    apb(0, 1'b0, 32'h10, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL err_ram_kept got %h want deadbeef", rd); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_ok_slverr got %b want 0", err); end
    apb(0, 1'b0, 32'h00100010, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_rd_data got %h want 0", rd); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_rd_slverr got %b want 1", err); end
    apb(0, 1'b0, 32'h0F000010, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin n_fail++; $display("FAIL err_slot_bits got %h/%b want deadbeef/0", rd, err); end
    apb(0, 1'b1, 32'h3FC, 32'hCAFE0001, rd, err, cyc, lows);
    apb(0, 1'b0, 32'h3FF, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (rd !== 32'hCAFE0001 || err !== 1'b0) begin n_fail++; $display("FAIL err_top_word got %h/%b want cafe0001/0", rd, err); end
    apb(0, 1'b0, 32'h400, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_first_oor got %b want 1", err); end
    apb(3, 1'b1, 32'h00100010, 32'h12345678, rd, err, cyc, lows);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL alias_wr_slverr got %b want 0", err); end
    apb(3, 1'b0, 32'h10, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL alias_rd got %h want 12345678", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int cyc, lows;
    logic [15:0] x0 = xcnt[0];
    for (int k = 0; k < 3; k++) begin
      apb(0, 1'b1, 32'(4 * k), 32'(k + 1), rd, err, cyc, lows);
      n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL b2b_len%0d got %0d want 2", k, cyc); end
    end
    n_cmp++; if (xcnt[0] !== 16'(x0 + 3)) begin n_fail++; $display("FAIL b2b_xfer got %0d want %0d", xcnt[0], x0 + 3); end
    apb(0, 1'b0, 32'h4, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL b2b_rd got %h want 2", rd); end
    x0 = xcnt[0];
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h77;
    @(negedge clk);
    n_cmp++; if (prot[0] !== 1'b1) begin n_fail++; $display("FAIL noset_prot got %b want 1", prot[0]); end
    n_cmp++; if (pready[0] !== 1'b0) begin n_fail++; $display("FAIL noset_pready got %b want 0", pready[0]); end
    psel[0] = 1'b0; penable = 1'b0;
    @(negedge clk);
    n_cmp++; if (xcnt[0] !== x0) begin n_fail++; $display("FAIL noset_xfer got %0d want %0d", xcnt[0], x0); end
    n_cmp++; if (prot[0] !== 1'b1) begin n_fail++; $display("FAIL prot_sticky got %b want 1", prot[0]); end
    apb(0, 1'b0, 32'h4, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL noset_nowr got %h want 2", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc, lows;
    apb(2, 1'b1, 32'h20, 32'hAAAA5555, rd, err, cyc, lows);
    n_cmp++; if (cyc !== 4) begin n_fail++; $display("FAIL ws2_len got %0d want 4", cyc); end
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h11111111;
    @(negedge clk);
    penable = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; psel[2] = 1'b0; penable = 1'b0;
    n_cmp++; if (pready[2] !== 1'b0) begin n_fail++; $display("FAIL midrst_pready got %b want 0", pready[2]); end
    n_cmp++; if (xcnt[2] !== 16'h0) begin n_fail++; $display("FAIL midrst_xfer got %0d want 0", xcnt[2]); end
    @(negedge clk);
    n_cmp++; if (pready[2] !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got %b want 0", pready[2]); end
    apb(2, 1'b0, 32'h20, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (rd !== 32'hAAAA5555) begin n_fail++; $display("FAIL midrst_rd got %h want aaaa5555", rd); end
    n_cmp++; if (cyc !== 4) begin n_fail++; $display("FAIL midrst_rd_len got %0d want 4", cyc); end
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h99;
    @(negedge clk);
    penable = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; psel[0] = 1'b0; penable = 1'b0;
    n_cmp++; if (xcnt[0] !== 16'h0) begin n_fail++; $display("FAIL rstcomp_xfer got %0d want 0", xcnt[0]); end
    apb(0, 1'b0, 32'h10, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rstcomp_rd got %h want deadbeef", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int cyc, lows;
    logic [15:0] x0 = xcnt[2];
    n_cmp++; if (prot[2] !== 1'b0) begin n_fail++; $display("FAIL abort_pre_prot got %b want 0", prot[2]); end
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h22222222;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel[2] = 1'b0; penable = 1'b0;
    @(negedge clk);
    n_cmp++; if (prot[2] !== 1'b1) begin n_fail++; $display("FAIL abort_prot got %b want 1", prot[2]); end
    n_cmp++; if (pready[2] !== 1'b0) begin n_fail++; $display("FAIL abort_pready got %b want 0", pready[2]); end
    n_cmp++; if (xcnt[2] !== x0) begin n_fail++; $display("FAIL abort_xfer got %0d want %0d", xcnt[2], x0); end
    apb(2, 1'b0, 32'h20, 32'h0, rd, err, cyc, lows);
    n_cmp++; if (rd !== 32'hAAAA5555) begin n_fail++; $display("FAIL abort_nowr got %h want aaaa5555", rd); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_wait();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
